// File: rtl/fp_ctrl_pkg.sv
// fp_ctrl_pkg: shared constants and FSM state type for the custom-0 FP sequencer
package fp_ctrl_pkg;
  localparam int FP_W = 32;
  localparam logic [2:0] F3_MAC16 = 3'b000;
  localparam logic [2:0] F3_DSQA = 3'b010;
  localparam logic [2:0] F3_DSQS = 3'b011;
  typedef enum logic [2:0] {S_IDLE, S_SUB, S_MUL, S_ACC, S_DONE} state_t;
endpackage

// File: rtl/fp_ctrl_mac16.sv
// fp_ctrl_mac16: y = acc + sext(a)*sext(b), 32-bit wrapping integer multiply-add
module fp_ctrl_mac16
  import fp_ctrl_pkg::*;
(
  input  logic [FP_W-1:0] acc,
  input  logic [15:0]     a,
  input  logic [15:0]     b,
  output logic [FP_W-1:0] y
);
  logic signed [31:0] p;
  assign p = $signed(a) * $signed(b);
  assign y = acc + $unsigned(p);
endmodule

// File: rtl/fp_dsqa_ctrl.sv
// fp_dsqa_ctrl: sequences custom-0 DSQA/DSQS (rd +/- (rs1-rs2)^2) over shared FP add/mul units
// Ports: cmd_* valid/ready command in, res_* one-cycle result out,
// add_*/mul_* start/done handshakes and operands to the shared FP units.
// FP_CTRL_MAC16_EN enables funct3 000 as an internal 16x16 signed integer MAC; otherwise it is illegal.
module fp_dsqa_ctrl
  import fp_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            n_reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_funct3,
  input  logic [FP_W-1:0] cmd_rs1,
  input  logic [FP_W-1:0] cmd_rs2,
  input  logic [FP_W-1:0] cmd_rd,
  output logic            res_valid,
  output logic [FP_W-1:0] res_data,
  output logic            res_err,
  output logic            add_start,
  output logic            mul_start,
  output logic            add_sub,
  output logic [FP_W-1:0] add_a,
  output logic [FP_W-1:0] add_b,
  output logic [FP_W-1:0] mul_a,
  output logic [FP_W-1:0] mul_b,
  input  logic            add_done,
  input  logic            mul_done,
  input  logic [FP_W-1:0] add_res,
  input  logic [FP_W-1:0] mul_res
);
  state_t          state;
  logic [2:0]      f3;
  logic [FP_W-1:0] rd_q;
  logic [FP_W-1:0] mac_y;
  logic            mac_ok;
`ifdef FP_CTRL_MAC16_EN
  logic [15:0] a16, b16;
  fp_ctrl_mac16 u_mac (.acc(rd_q), .a(a16), .b(b16), .y(mac_y));
  assign mac_ok = f3 == F3_MAC16;
`else
  assign mac_y  = rd_q;
  assign mac_ok = 1'b0;
`endif
  // Commands that bypass the FP units spend two cycles in DONE: the first
  // (res_valid still low) forms the result, the second presents it.
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_data  <= '0;
      add_start <= 1'b0;
      mul_start <= 1'b0;
      add_sub   <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      f3        <= '0;
      rd_q      <= '0;
`ifdef FP_CTRL_MAC16_EN
      a16       <= '0;
      b16       <= '0;
`endif
    end else begin
      add_start <= 1'b0;
      mul_start <= 1'b0;
      case (state)
        S_IDLE:
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            f3        <= cmd_funct3;
            rd_q      <= cmd_rd;
`ifdef FP_CTRL_MAC16_EN
            a16       <= cmd_rs1[15:0];
            b16       <= cmd_rs2[15:0];
`endif
            if (cmd_funct3 == F3_DSQA || cmd_funct3 == F3_DSQS) begin
              state     <= S_SUB;
              add_start <= 1'b1;
              add_sub   <= 1'b1;
              add_a     <= cmd_rs1;
              add_b     <= cmd_rs2;
            end else
              state <= S_DONE;
          end
        S_SUB:
          if (add_done) begin
            state     <= S_MUL;
            mul_start <= 1'b1;
            mul_a     <= add_res;
            mul_b     <= add_res;
          end
        S_MUL:
          if (mul_done) begin
            state     <= S_ACC;
            add_start <= 1'b1;
            add_a     <= rd_q;
            add_b     <= mul_res;
            add_sub   <= f3 == F3_DSQS;
          end
        S_ACC:
          if (add_done) begin
            state     <= S_DONE;
            res_valid <= 1'b1;
            res_err   <= 1'b0;
            res_data  <= add_res;
          end
        S_DONE:
          if (res_valid) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            res_valid <= 1'b1;
            res_err   <= !mac_ok;
            res_data  <= mac_ok ? mac_y : rd_q;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_fp_dsqa_ctrl.sv
// tb_fp_dsqa_ctrl: scoreboard bench for fp_dsqa_ctrl with behavioural FP add/mul units
module tb_fp_dsqa_ctrl;
  import fp_ctrl_pkg::*;
  logic clk = 0, n_reset = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [2:0] cmd_funct3 = 0;
  logic [31:0] cmd_rs1 = 0, cmd_rs2 = 0, cmd_rd = 0;
  logic res_valid, res_err, add_start, mul_start, add_sub, add_done, mul_done;
  logic [31:0] res_data, add_a, add_b, mul_a, mul_b, add_res, mul_res;
  fp_dsqa_ctrl dut (
    .clk(clk), .n_reset(n_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_funct3(cmd_funct3), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .add_start(add_start), .mul_start(mul_start), .add_sub(add_sub),
    .add_a(add_a), .add_b(add_b), .mul_a(mul_a), .mul_b(mul_b),
    .add_done(add_done), .mul_done(mul_done), .add_res(add_res), .mul_res(mul_res)
  );
  always #5 clk = ~clk;
  typedef struct packed { logic [31:0] d; logic err; } exp_t;
  exp_t sbq[$];
  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic real f2r(input logic [31:0] f);
    if (f[30:0] == 31'd0) return $bitstoreal({f[31], 63'd0});
    return $bitstoreal({f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0});
  endfunction
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e11;
    logic [30:0] em;
    logic [28:0] rem;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e11 = d[62:52] - 11'd896;
    em  = {e11[7:0], d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && em[0])) em = em + 31'd1;
    return {d[63], em};
  endfunction
  int add_lat = 3, mul_lat = 3, add_cnt = 0, mul_cnt = 0, n_add = 0, n_mul = 0, n_sub1 = 0;
  logic [31:0] add_r = 0, mul_r = 0;
  logic stray_add = 0, stray_mul = 0;
  always @(posedge clk) begin
    if (add_start) begin
      add_cnt <= add_lat;
      add_r   <= r2f(add_sub ? f2r(add_a) - f2r(add_b) : f2r(add_a) + f2r(add_b));
      n_add   <= n_add + 1;
      n_sub1  <= n_sub1 + int'(add_sub);
    end else if (add_cnt > 0) add_cnt <= add_cnt - 1;
    if (mul_start) begin
      mul_cnt <= mul_lat;
      mul_r   <= r2f(f2r(mul_a) * f2r(mul_b));
      n_mul   <= n_mul + 1;
    end else if (mul_cnt > 0) mul_cnt <= mul_cnt - 1;
  end
  assign add_done = (add_cnt == 1) | stray_add;
  assign mul_done = (mul_cnt == 1) | stray_mul;
  assign add_res  = add_r;
  assign mul_res  = mul_r;
  task automatic run_cmd(input logic [2:0] f, input logic [31:0] r1, r2, rd, ed, input logic ee,
                         input int elat, eadd, emul, input bit hold, output int waited, output int sub1);
    exp_t e;
    int acc, na, nm, ns;
    bit got, busy_ok;
    cmd_funct3 = f; cmd_rs1 = r1; cmd_rs2 = r2; cmd_rd = rd; cmd_valid = 1;
    sbq.push_back('{d: ed, err: ee});
    waited = 0;
    sub1 = 0;
    while (!cmd_ready && waited < 100) begin @(negedge clk); waited++; end
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL accept: cmd_ready=%b required 1", cmd_ready); end
    acc = cyc; na = n_add; nm = n_mul; ns = n_sub1;
    @(negedge clk);
    cmd_valid = hold;
    got = 0; busy_ok = 1;
    for (int i = 0; i < 300; i++) begin
      if (res_valid) begin got = 1; break; end
      if (cmd_ready !== 1'b0) busy_ok = 0;
      @(negedge clk);
    end
    e = sbq.pop_front();
    tests++;
    if (!got) begin fails++; $display("FAIL result_timeout: res_valid never seen, required f3=%b", f); return; end
    sub1 = n_sub1 - ns;
    tests++;
    if (res_data !== e.d) begin fails++; $display("FAIL res_data: got %h required %h", res_data, e.d); end
    tests++;
    if (res_err !== e.err) begin fails++; $display("FAIL res_err: got %b required %b", res_err, e.err); end
    tests++;
    if (cyc - acc !== elat) begin fails++; $display("FAIL latency: got %0d required %0d", cyc - acc, elat); end
    tests++;
    if (!busy_ok || cmd_ready !== 1'b0) begin fails++; $display("FAIL busy_ready: cmd_ready rose before result, required 0"); end
    tests++;
    if (n_add - na !== eadd || n_mul - nm !== emul)
      begin fails++; $display("FAIL starts: add=%0d mul=%0d required add=%0d mul=%0d", n_add - na, n_mul - nm, eadd, emul); end
    if (!hold) begin
      @(negedge clk);
      tests++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1)
        begin fails++; $display("FAIL pulse_end: res_valid=%b cmd_ready=%b required 0 1", res_valid, cmd_ready); end
    end
  endtask
  task automatic test_reset;
    n_reset = 0;
    repeat (2) @(negedge clk);
    tests++;
    if ({cmd_ready, res_valid, res_err, add_start, mul_start, add_sub} !== 6'b100000 ||
        {res_data, add_a, add_b, mul_a, mul_b} !== 160'd0)
      begin fails++; $display("FAIL reset_vals: ctl=%b data=%h required 100000 0", {cmd_ready, res_valid, res_err, add_start, mul_start, add_sub}, res_data); end
    n_reset = 1;
    @(negedge clk);
  endtask
  task automatic test_dsqa;
    int w, s;
    add_lat = 4; mul_lat = 4;
    run_cmd(F3_DSQA, 32'h420A3D71, 32'h0, 32'hC4960000, 32'hC0B36700, 0, 16, 2, 1, 0, w, s);
  endtask
  task automatic test_back_to_back;
    int w, s;
    add_lat = 1; mul_lat = 5;
    run_cmd(F3_DSQA, 32'hC0228F5C, 32'h3EEB851F, 32'hC0B36700, 32'h40593200, 0, 11, 2, 1, 1, w, s);
    tests++;
    if (s !== 1) begin fails++; $display("FAIL dsqa_sub: add_sub=1 starts %0d required 1", s); end
    run_cmd(F3_DSQA, 32'h40400000, 32'h3F800000, 32'h0, 32'h40800000, 0, 11, 2, 1, 0, w, s);
    tests++;
    if (w !== 1) begin fails++; $display("FAIL chain_accept: waited %0d required 1", w); end
  endtask
  task automatic test_dsqs;
    int w, s;
    add_lat = 2; mul_lat = 1;
    run_cmd(F3_DSQS, 32'h40400000, 32'h3F800000, 32'h41200000, 32'h40C00000, 0, 9, 2, 1, 0, w, s);
    tests++;
    if (s !== 2) begin fails++; $display("FAIL dsqs_sub: add_sub=1 starts %0d required 2", s); end
  endtask
  task automatic test_illegal;
    int w, s;
    run_cmd(3'b101, $urandom, $urandom, 32'h12345678, 32'h12345678, 1, 2, 0, 0, 0, w, s);
  endtask
  task automatic test_mac16;
    int w, s;
`ifdef FP_CTRL_MAC16_EN
    run_cmd(F3_MAC16, 32'h0000FFFE, 32'h5, 32'h3, 32'hFFFFFFF9, 0, 2, 0, 0, 0, w, s);
`else
    run_cmd(F3_MAC16, 32'h0000FFFE, 32'h5, 32'h3, 32'h3, 1, 2, 0, 0, 0, w, s);
`endif
  endtask
  task automatic test_reset_abort;
    bit seen, bad;
    add_lat = 2; mul_lat = 6;
    cmd_funct3 = F3_DSQA; cmd_rs1 = 32'h40400000; cmd_rs2 = 32'h3F800000; cmd_rd = 32'h0; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (mul_start) begin seen = 1; break; end
      @(negedge clk);
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL abort_mul: mul_start=0 required 1"); end
    @(negedge clk);
    n_reset = 0;
    #1;
    tests++;
    if ({cmd_ready, res_valid, res_err, add_start, mul_start} !== 5'b10000 || {res_data, mul_a} !== 64'd0)
      begin fails++; $display("FAIL abort_vals: ctl=%b required 10000", {cmd_ready, res_valid, res_err, add_start, mul_start}); end
    @(negedge clk);
    n_reset = 1;
    @(negedge clk);
    stray_mul = 1; stray_add = 1;
    @(negedge clk);
    stray_mul = 0; stray_add = 0;
    bad = 0;
    repeat (15) begin
      if (res_valid || add_start || mul_start || !cmd_ready) bad = 1;
      @(negedge clk);
    end
    tests++;
    if (bad) begin fails++; $display("FAIL abort_ignore: activity after reset, required idle"); end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    test_reset;
    test_dsqa;
    test_back_to_back;
    test_dsqs;
    test_illegal;
    test_mac16;
    test_reset_abort;
    test_dsqa;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
